// File: rtl/pipe_hz_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hz_pkg
// Shared definitions for the pipeline sequencing controller and its helpers.
//   hz_state_t  : controller state enum {RUN, MEM_WAIT, DRAIN, HALTED, STEP}
//   HZ_REG_ZERO : architectural x0, which never carries a real dependency
//   hz_max      : elaboration-time helper used to size shared counters
// ---------------------------------------------------------------------------
package pipe_hz_pkg;

   typedef enum logic [2:0] {
      RUN      = 3'd0,
      MEM_WAIT = 3'd1,
      DRAIN    = 3'd2,
      HALTED   = 3'd3,
      STEP     = 3'd4
   } hz_state_t;

   localparam logic [4:0] HZ_REG_ZERO = 5'd0;

   function automatic int hz_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard comparator. Raises stall_req when the
// instruction in EX is a load whose destination (other than x0) is read by
// the instruction currently in ID. Kept separate so the forwarding unit can
// reuse it.
// Ports:
//   IFID_rs1, IFID_rs2 : source registers of the instruction in ID
//   IDEX_rd            : destination register of the instruction in EX
//   IDEX_MemRead       : the instruction in EX is a load
//   stall_req          : a one-cycle load-use bubble is required
// ---------------------------------------------------------------------------
module load_use_detect
   import pipe_hz_pkg::*;
(
   input  logic [4:0] IFID_rs1,
   input  logic [4:0] IFID_rs2,
   input  logic [4:0] IDEX_rd,
   input  logic       IDEX_MemRead,
   output logic       stall_req
);

   // A load into x0 produces nothing, so it can never create a dependency.
   always_comb begin
      stall_req = IDEX_MemRead && (IDEX_rd != HZ_REG_ZERO) &&
                  ((IDEX_rd == IFID_rs1) || (IDEX_rd == IFID_rs2));
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Pipeline sequencing controller for the 5-stage RV32I core. Drives the PC
// enable and the enable/clear pins of the IF/ID, ID/EX, EX/MEM and MEM/WB
// registers, resolving load-use stalls, branch/JAL flushes and memory wait
// states, and providing a debug halt / single-step mechanism.
//
// Parameters:
//   MEM_TIMEOUT  : consecutive memory wait cycles before mem_err (1..65535)
//   DRAIN_CYCLES : NOP-injection cycles that empty the pipe on halt (1..15)
// Ports:
//   CLOCK, RST_n         : rising-edge clock, asynchronous active-low reset
//   IFID_rs1/rs2         : sources of the instruction in ID
//   IDEX_rd, IDEX_MemRead: destination / load flag of the instruction in EX
//   PCSrc_EX             : taken branch or JAL resolved in EX
//   mem_req, mem_ready   : MEM stage access and its completion
//   halt_req, step_req   : debug halt level and single-step pulse
//   EN_*                 : stage register enables, active-high
//   clear_*              : stage register clears, active-low (0 = bubble)
//   halted, mem_err      : in HALTED / sticky memory-timeout flag
// Optional feature (macro PIPE_HZ_PERF_EN):
//   perf_clr             : synchronous clear of the performance counters
//   stall_cnt, flush_cnt, wait_cnt : saturating 32-bit counts of cycles in
//                          which the load-use, flush or freeze rule won
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
   import pipe_hz_pkg::*;
#(
   parameter int MEM_TIMEOUT  = 255,
   parameter int DRAIN_CYCLES = 4
) (
   input  logic        CLOCK,
   input  logic        RST_n,
   input  logic [4:0]  IFID_rs1,
   input  logic [4:0]  IFID_rs2,
   input  logic [4:0]  IDEX_rd,
   input  logic        IDEX_MemRead,
   input  logic        PCSrc_EX,
   input  logic        mem_req,
   input  logic        mem_ready,
   input  logic        halt_req,
   input  logic        step_req,
`ifdef PIPE_HZ_PERF_EN
   input  logic        perf_clr,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt,
   output logic [31:0] wait_cnt,
`endif
   output logic        EN_PC,
   output logic        EN_IFID,
   output logic        EN_IDEX,
   output logic        EN_EXMEM,
   output logic        EN_MEMWB,
   output logic        clear_IFID,
   output logic        clear_IDEX,
   output logic        clear_EXMEM,
   output logic        halted,
   output logic        mem_err
);

   // One counter serves both the memory wait and the drain phases, so it is
   // wide enough for whichever limit is larger.
   localparam int CNT_W  = hz_max($clog2(MEM_TIMEOUT + 1), $clog2(DRAIN_CYCLES + 1));
   localparam int CNT_W1 = CNT_W + 1;
   localparam logic [CNT_W:0] TIMEOUT_LIM = CNT_W1'(MEM_TIMEOUT);
   localparam logic [CNT_W:0] DRAIN_LIM   = CNT_W1'(DRAIN_CYCLES);

   hz_state_t         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  cnt_sat;
   logic [CNT_W:0]    cnt_plus1;
   logic              mem_err_q, mem_err_d;
   logic              freeze;
   logic              stall_req;

   load_use_detect u_load_use_detect (
      .IFID_rs1     (IFID_rs1),
      .IFID_rs2     (IFID_rs2),
      .IDEX_rd      (IDEX_rd),
      .IDEX_MemRead (IDEX_MemRead),
      .stall_req    (stall_req)
   );

   // The memory freeze condition and the counter arithmetic. cnt_plus1 is one
   // bit wider so the limit comparison cannot overflow; cnt_sat is the
   // saturating increment that is actually stored.
   always_comb begin
      freeze    = mem_req && !mem_ready;
      cnt_plus1 = {1'b0, cnt_q} + CNT_W1'(1);
      cnt_sat   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
   end

   // State, wait/drain counter and sticky error flag. Reset returns straight
   // to RUN with a cleared counter and error flag.
   always_ff @(posedge CLOCK or negedge RST_n) begin
      if (!RST_n) begin
         state_q   <= RUN;
         cnt_q     <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mem_err_q <= mem_err_d;
      end
   end

   // Next-state and output logic. HALTED ignores the memory interface
   // entirely. Everywhere else a freeze wins over everything; otherwise a
   // flush beats a load-use stall, and DRAIN additionally keeps the PC held
   // and feeds NOPs into ID. The counter counts completed wait cycles in
   // MEM_WAIT (the RUN cycle that starts the wait is the first) and
   // non-frozen cycles in DRAIN. Leaving MEM_WAIT always goes through RUN so
   // a pending halt is seen only after the access has completed.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mem_err_d   = mem_err_q;
      EN_PC       = 1'b1;
      EN_IFID     = 1'b1;
      EN_IDEX     = 1'b1;
      EN_EXMEM    = 1'b1;
      EN_MEMWB    = 1'b1;
      clear_IFID  = 1'b1;
      clear_IDEX  = 1'b1;
      clear_EXMEM = 1'b1;
      halted      = 1'b0;

      if (state_q == HALTED) begin
         EN_PC    = 1'b0;
         EN_IFID  = 1'b0;
         EN_IDEX  = 1'b0;
         EN_EXMEM = 1'b0;
         EN_MEMWB = 1'b0;
         halted   = 1'b1;
         if (step_req) begin
            state_d = STEP;
         end else if (!halt_req && !mem_err_q) begin
            state_d = RUN;
         end
      end else if (freeze) begin
         EN_PC    = 1'b0;
         EN_IFID  = 1'b0;
         EN_IDEX  = 1'b0;
         EN_EXMEM = 1'b0;
         EN_MEMWB = 1'b0;
         case (state_q)
            RUN: begin
               if (MEM_TIMEOUT <= 1) begin
                  state_d   = HALTED;
                  mem_err_d = 1'b1;
               end else begin
                  state_d = MEM_WAIT;
                  cnt_d   = CNT_W'(1);
               end
            end
            MEM_WAIT: begin
               if (cnt_plus1 >= TIMEOUT_LIM) begin
                  state_d   = HALTED;
                  mem_err_d = 1'b1;
               end else begin
                  cnt_d = cnt_sat;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end else begin
         if (PCSrc_EX) begin
            clear_IFID = 1'b0;
            clear_IDEX = 1'b0;
         end else if (stall_req) begin
            EN_PC      = 1'b0;
            EN_IFID    = 1'b0;
            clear_IDEX = 1'b0;
         end
         if (state_q == DRAIN) begin
            EN_PC      = 1'b0;
            clear_IFID = 1'b0;
         end
         case (state_q)
            RUN: begin
               if (halt_req) begin
                  state_d = DRAIN;
                  cnt_d   = '0;
               end
            end
            MEM_WAIT: begin
               state_d = RUN;
               cnt_d   = '0;
            end
            DRAIN: begin
               if (cnt_plus1 >= DRAIN_LIM) begin
                  state_d = HALTED;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_sat;
               end
            end
            STEP: begin
               state_d = DRAIN;
               cnt_d   = '0;
            end
            default: begin
               state_d = RUN;
               cnt_d   = '0;
            end
         endcase
      end

      if (!RST_n) begin
         EN_PC       = 1'b0;
         EN_IFID     = 1'b0;
         EN_IDEX     = 1'b0;
         EN_EXMEM    = 1'b0;
         EN_MEMWB    = 1'b0;
         clear_IFID  = 1'b1;
         clear_IDEX  = 1'b1;
         clear_EXMEM = 1'b1;
         halted      = 1'b0;
      end
   end

   // The error flag is only ever set by a timeout and cleared by reset.
   always_comb begin
      mem_err = mem_err_q;
   end

`ifdef PIPE_HZ_PERF_EN
   logic win_freeze, win_flush, win_stall;

   // Which rule won this cycle, mirroring the priority used above. HALTED
   // has no winning rule because nothing is in motion.
   always_comb begin
      win_freeze = (state_q != HALTED) && freeze;
      win_flush  = (state_q != HALTED) && !freeze && PCSrc_EX;
      win_stall  = (state_q != HALTED) && !freeze && !PCSrc_EX && stall_req;
   end

   // Saturating event counters with a synchronous clear.
   always_ff @(posedge CLOCK or negedge RST_n) begin
      if (!RST_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
         wait_cnt  <= '0;
      end else if (perf_clr) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
         wait_cnt  <= '0;
      end else begin
         if (win_stall && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (win_flush && !(&flush_cnt)) begin
            flush_cnt <= flush_cnt + 32'd1;
         end
         if (win_freeze && !(&wait_cnt)) begin
            wait_cnt <= wait_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Scoreboard bench for pipe_hazard_ctrl. The stimulus process drives one
// cycle of inputs shortly after each rising edge, asks a behavioural model
// for the outputs that cycle should show and queues them; a monitor samples
// the DUT on every falling edge and compares against the queue head.
// Directed sequences cover stalls, x0, flush priority, freeze, timeout and
// halt/step; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

   localparam int MEM_TIMEOUT  = 4;
   localparam int DRAIN_CYCLES = 4;

   logic       CLOCK = 1'b0;
   logic       RST_n = 1'b0;
   logic [4:0] IFID_rs1 = '0;
   logic [4:0] IFID_rs2 = '0;
   logic [4:0] IDEX_rd = '0;
   logic       IDEX_MemRead = 1'b0;
   logic       PCSrc_EX = 1'b0;
   logic       mem_req = 1'b0;
   logic       mem_ready = 1'b0;
   logic       halt_req = 1'b0;
   logic       step_req = 1'b0;
   logic       EN_PC, EN_IFID, EN_IDEX, EN_EXMEM, EN_MEMWB;
   logic       clear_IFID, clear_IDEX, clear_EXMEM;
   logic       halted, mem_err;
   logic [9:0] act_vec;

`ifdef PIPE_HZ_PERF_EN
   logic        perf_clr = 1'b0;
   logic [31:0] stall_cnt, flush_cnt, wait_cnt;
`endif

   logic [9:0] exp_q[$];
   int         checks_total = 0;
   int         checks_passed = 0;
   int         cycle_no = 0;

   // Reference model: a halted flag, a pending single step, a drain countdown,
   // a run of consecutive memory waits and the sticky error.
   bit m_halted = 1'b0;
   bit m_step = 1'b0;
   bit m_draining = 1'b0;
   bit m_err = 1'b0;
   int m_drain_left = 0;
   int m_waits = 0;
   int m_stalls = 0;
   int m_flushes = 0;
   int m_freezes = 0;

   always #5 CLOCK = ~CLOCK;

   pipe_hazard_ctrl #(
      .MEM_TIMEOUT  (MEM_TIMEOUT),
      .DRAIN_CYCLES (DRAIN_CYCLES)
   ) dut (
      .CLOCK        (CLOCK),
      .RST_n        (RST_n),
      .IFID_rs1     (IFID_rs1),
      .IFID_rs2     (IFID_rs2),
      .IDEX_rd      (IDEX_rd),
      .IDEX_MemRead (IDEX_MemRead),
      .PCSrc_EX     (PCSrc_EX),
      .mem_req      (mem_req),
      .mem_ready    (mem_ready),
      .halt_req     (halt_req),
      .step_req     (step_req),
`ifdef PIPE_HZ_PERF_EN
      .perf_clr     (perf_clr),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt),
      .wait_cnt     (wait_cnt),
`endif
      .EN_PC        (EN_PC),
      .EN_IFID      (EN_IFID),
      .EN_IDEX      (EN_IDEX),
      .EN_EXMEM     (EN_EXMEM),
      .EN_MEMWB     (EN_MEMWB),
      .clear_IFID   (clear_IFID),
      .clear_IDEX   (clear_IDEX),
      .clear_EXMEM  (clear_EXMEM),
      .halted       (halted),
      .mem_err      (mem_err)
   );

   assign act_vec = {EN_PC, EN_IFID, EN_IDEX, EN_EXMEM, EN_MEMWB,
                     clear_IFID, clear_IDEX, clear_EXMEM, halted, mem_err};

   // Drive one cycle of inputs, queue the outputs the model predicts for it,
   // then advance the model to where it stands after the coming edge.
   task automatic applyStimulus(input int rst_n_v, input int rs1, input int rs2,
                                input int rd, input int memread, input int pcsrc,
                                input int mreq, input int mrdy, input int hreq,
                                input int sreq);
      bit freeze, hazard, flush;
      bit e_pc, e_ifid, e_idex, e_exmem, e_memwb, c_ifid, c_idex, e_halted;
      @(posedge CLOCK);
      #1;
      RST_n        = (rst_n_v != 0);
      IFID_rs1     = 5'(rs1);
      IFID_rs2     = 5'(rs2);
      IDEX_rd      = 5'(rd);
      IDEX_MemRead = (memread != 0);
      PCSrc_EX     = (pcsrc != 0);
      mem_req      = (mreq != 0);
      mem_ready    = (mrdy != 0);
      halt_req     = (hreq != 0);
      step_req     = (sreq != 0);
      cycle_no++;

      freeze = (mreq != 0) && (mrdy == 0);
      flush  = (pcsrc != 0);
      hazard = (memread != 0) && (rd != 0) && ((rd == rs1) || (rd == rs2));

      e_pc = 1'b1; e_ifid = 1'b1; e_idex = 1'b1; e_exmem = 1'b1; e_memwb = 1'b1;
      c_ifid = 1'b1; c_idex = 1'b1; e_halted = 1'b0;
      if (rst_n_v == 0) begin
         e_pc = 1'b0; e_ifid = 1'b0; e_idex = 1'b0; e_exmem = 1'b0; e_memwb = 1'b0;
      end else if (m_halted) begin
         e_pc = 1'b0; e_ifid = 1'b0; e_idex = 1'b0; e_exmem = 1'b0; e_memwb = 1'b0;
         e_halted = 1'b1;
      end else if (freeze) begin
         e_pc = 1'b0; e_ifid = 1'b0; e_idex = 1'b0; e_exmem = 1'b0; e_memwb = 1'b0;
         m_freezes++;
      end else begin
         if (flush) begin
            c_ifid = 1'b0; c_idex = 1'b0;
            m_flushes++;
         end else if (hazard) begin
            e_pc = 1'b0; e_ifid = 1'b0; c_idex = 1'b0;
            m_stalls++;
         end
         if (m_draining) begin
            e_pc = 1'b0; c_ifid = 1'b0;
         end
      end
      exp_q.push_back({e_pc, e_ifid, e_idex, e_exmem, e_memwb, c_ifid, c_idex,
                       1'b1, e_halted, (rst_n_v != 0) && m_err});

      if (rst_n_v == 0) begin
         m_halted = 1'b0; m_step = 1'b0; m_draining = 1'b0; m_err = 1'b0;
         m_drain_left = 0; m_waits = 0;
         m_stalls = 0; m_flushes = 0; m_freezes = 0;
      end else if (m_halted) begin
         if (sreq != 0) begin
            m_halted = 1'b0; m_step = 1'b1;
         end else if (hreq == 0 && !m_err) begin
            m_halted = 1'b0;
         end
      end else if (m_step) begin
         if (!freeze) begin
            m_step = 1'b0; m_draining = 1'b1; m_drain_left = DRAIN_CYCLES;
         end
      end else if (m_draining) begin
         if (!freeze) begin
            m_drain_left--;
            if (m_drain_left == 0) begin
               m_draining = 1'b0; m_halted = 1'b1;
            end
         end
      end else if (freeze) begin
         m_waits++;
         if (m_waits >= MEM_TIMEOUT) begin
            m_err = 1'b1; m_halted = 1'b1; m_waits = 0;
         end
      end else if (m_waits > 0) begin
         m_waits = 0;
      end else if (hreq != 0) begin
         m_draining = 1'b1; m_drain_left = DRAIN_CYCLES;
      end
   endtask

   task automatic idleCycles(input int n, input int hreq);
      for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, hreq, 0);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] req);
      checks_total++;
      if (act === req) begin
         checks_passed++;
      end else begin
         $display("[TB] FAIL %s cycle %0d: actual=%b required=%b",
                  name, cycle_no, act, req);
      end
   endtask

   // Monitor: every cycle presents a full output vector, compared against
   // the oldest queued prediction.
   initial begin
      forever begin
         @(negedge CLOCK);
         if (exp_q.size() > 0) begin
            checkOutput("outputs", 32'(act_vec), 32'(exp_q.pop_front()));
         end
      end
   end

   // Stimulus: reset, directed scenarios, then randomized traffic.
   initial begin
      int hold_halt;
      int r;
      $display("[TB] start");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
      idleCycles(2, 0);

      applyStimulus(1, 5, 0, 5, 1, 0, 0, 0, 0, 0);
      idleCycles(1, 0);
      applyStimulus(1, 3, 0, 0, 1, 0, 0, 0, 0, 0);
      applyStimulus(1, 7, 7, 7, 1, 1, 0, 0, 0, 0);
      applyStimulus(1, 9, 6, 6, 1, 0, 0, 0, 0, 0);
      idleCycles(1, 0);

      for (int i = 0; i < 3; i++) applyStimulus(1, 4, 0, 4, 1, 1, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      idleCycles(2, 0);

      for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      idleCycles(3, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idleCycles(2, 0);

      idleCycles(7, 1);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      idleCycles(7, 1);
      idleCycles(3, 0);

      hold_halt = 0;
      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 5) hold_halt = 1 - hold_halt;
         applyStimulus((r == 50) ? 0 : 1,
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                       ($urandom_range(0, 99) < 20) ? 1 : 0,
                       ($urandom_range(0, 99) < 35) ? 1 : 0,
                       ($urandom_range(0, 99) < 45) ? 1 : 0,
                       hold_halt,
                       ($urandom_range(0, 99) < 10) ? 1 : 0);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 2, 0, 2, 1, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 1, 1, 1, 0, 0, 0, 0, 0);
      idleCycles(2, 0);

      @(negedge CLOCK);
      #1;
`ifdef PIPE_HZ_PERF_EN
      checkOutput("stall_cnt", stall_cnt, 32'(m_stalls));
      checkOutput("flush_cnt", flush_cnt, 32'(m_flushes));
      checkOutput("wait_cnt", wait_cnt, 32'(m_freezes));
`endif
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
